// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: default register addresses, arbiter state encoding and bus payload.
package nes_bus_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [ADDR_W-1:0] DMA_REG_DEF  = 16'h4014;
  localparam logic [ADDR_W-1:0] OAM_DATA_DEF = 16'h2004;

  typedef enum logic [STATE_W-1:0] {
    ST_CPU     = 3'd0,
    ST_SYS     = 3'd1,
    ST_DMA_ALN = 3'd2,
    ST_DMA_RD  = 3'd3,
    ST_DMA_WT  = 3'd4,
    ST_DMA_WR  = 3'd5
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
  } bus_req_t;

  // Source address of one OAM DMA byte: page in the high byte, index in the low byte.
  function automatic logic [ADDR_W-1:0] dma_src_addr(input logic [DATA_W-1:0] page,
                                                     input logic [DATA_W-1:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_oam_dma_seq.sv
// OAM DMA datapath: source page latch, byte index, read-latency counter and captured data byte.
module oam_dma_seq
  import nes_bus_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_page,
  input  logic              wt_step,
  input  logic              wr_step,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] page,
  output logic [DATA_W-1:0] idx,
  output logic [DATA_W-1:0] dbyte,
  output logic              lat_last_c,
  output logic              done_c
);

  localparam int unsigned LAT_W = 2;

  logic [LAT_W-1:0] lat_cnt;

  // Counters only move on step strobes, which the arbiter withholds while mem_ctrl is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      page    <= '0;
      idx     <= '0;
      dbyte   <= '0;
      lat_cnt <= '0;
    end else if (load) begin
      page    <= load_page;
      idx     <= '0;
      lat_cnt <= '0;
    end else begin
      if (wt_step) begin
        if (lat_last_c) begin
          dbyte   <= mem_rdata;
          lat_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end
      if (wr_step) begin
        idx <= idx + DATA_W'(1);
      end
    end
  end

  assign lat_last_c = (lat_cnt == LAT_W'(MEM_RD_LAT - 1));
  assign done_c     = (idx == {DATA_W{1'b1}});

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the mem_ctrl CPU-side port between sys_ctrl, the 6502 and the OAM DMA sequencer,
// and produces the combined CPU halt.
module mem_bus_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG    = DMA_REG_DEF,
  parameter logic [ADDR_W-1:0] OAM_DATA   = OAM_DATA_DEF,
  parameter int unsigned       MEM_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sys_req,
  input  logic [ADDR_W-1:0]  sys_addr,
  input  logic [DATA_W-1:0]  sys_wdata,
  input  logic               sys_we,
  input  logic               sys_re,
  output logic               sys_gnt,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic               cpu_halt_ext,
  output logic               cpu_halt,
  input  logic               mem_busy,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               dma_active,
  output logic [STATE_W-1:0] arb_state
);

  arb_state_e        state;
  logic              dma_pend;
  logic [DATA_W-1:0] page;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] dbyte;
  logic              lat_last_c;
  logic              done_c;
  logic              dma_trig_c;
  logic              wt_step_c;
  logic              wr_step_c;
  bus_req_t          cpu_bus_c;
  bus_req_t          sys_bus_c;
  bus_req_t          dma_bus_c;
  bus_req_t          bus_c;

  assign dma_trig_c = (state == ST_CPU) && cpu_we && (cpu_addr == DMA_REG) && !mem_busy;
  assign wt_step_c  = (state == ST_DMA_WT) && !mem_busy;
  assign wr_step_c  = (state == ST_DMA_WR) && !mem_busy;

  oam_dma_seq #(
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_dma_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (dma_trig_c),
    .load_page  (cpu_wdata),
    .wt_step    (wt_step_c),
    .wr_step    (wr_step_c),
    .mem_rdata  (mem_rdata),
    .page       (page),
    .idx        (idx),
    .dbyte      (dbyte),
    .lat_last_c (lat_last_c),
    .done_c     (done_c)
  );

  // Arbiter FSM; mem_busy freezes every transition so a stalled strobe is simply reissued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_CPU;
      sys_gnt    <= 1'b0;
      dma_pend   <= 1'b0;
      dma_active <= 1'b0;
    end else if (!mem_busy) begin
      unique case (state)
        ST_CPU: begin
          if (dma_trig_c) begin
            dma_pend   <= 1'b1;
            dma_active <= 1'b1;
          end
          if (sys_req) begin
            state   <= ST_SYS;
            sys_gnt <= 1'b1;
          end else if (dma_trig_c) begin
            state <= ST_DMA_ALN;
          end
        end
        ST_SYS: begin
          if (!sys_req) begin
            sys_gnt <= 1'b0;
            state   <= dma_pend ? ST_DMA_RD : ST_CPU;
          end
        end
        ST_DMA_ALN: state <= ST_DMA_RD;
        ST_DMA_RD:  state <= ST_DMA_WT;
        ST_DMA_WT: begin
          if (lat_last_c) begin
            state <= ST_DMA_WR;
          end
        end
        ST_DMA_WR: begin
          // sys_req is only honoured here, after a whole byte has been moved.
          if (done_c) begin
            state      <= ST_CPU;
            dma_pend   <= 1'b0;
            dma_active <= 1'b0;
          end else if (sys_req) begin
            state   <= ST_SYS;
            sys_gnt <= 1'b1;
          end else begin
            state <= ST_DMA_RD;
          end
        end
        default: state <= ST_CPU;
      endcase
    end
  end

  // Bus mux; strobes are suppressed while mem_ctrl is busy and during reset.
  always_comb begin
    cpu_bus_c = '{addr: cpu_addr, wdata: cpu_wdata, we: cpu_we, re: cpu_re};
    sys_bus_c = '{addr: sys_addr, wdata: sys_wdata, we: sys_we & sys_gnt, re: sys_re & sys_gnt};
    dma_bus_c = '0;
    if (state == ST_DMA_WR) begin
      dma_bus_c.addr  = OAM_DATA;
      dma_bus_c.wdata = dbyte;
      dma_bus_c.we    = 1'b1;
    end else begin
      dma_bus_c.addr = dma_src_addr(page, idx);
      dma_bus_c.re   = 1'b1;
    end
    bus_c = '0;
    unique case (state)
      ST_CPU:               bus_c = cpu_bus_c;
      ST_SYS:               bus_c = sys_bus_c;
      ST_DMA_RD, ST_DMA_WR: bus_c = dma_bus_c;
      default:              bus_c = '0;
    endcase
    if (mem_busy || rst) begin
      bus_c.we = 1'b0;
      bus_c.re = 1'b0;
    end
  end

  assign mem_addr  = bus_c.addr;
  assign mem_wdata = bus_c.wdata;
  assign mem_we    = bus_c.we;
  assign mem_re    = bus_c.re;

  assign cpu_halt  = cpu_halt_ext | mem_busy | (state != ST_CPU) | sys_req | dma_pend;
  assign arb_state = STATE_W'(state);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: OAM DMA byte stream, sys preemption, stalls and reset.
module tb_mem_bus_arbiter;

  localparam int unsigned LAT     = 2;
  localparam int          DMA_CYC = 1 + 256 * (2 + LAT);

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_req;
  logic [15:0] sys_addr;
  logic [7:0]  sys_wdata;
  logic        sys_we;
  logic        sys_re;
  logic        sys_gnt;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_halt_ext;
  logic        cpu_halt;
  logic        mem_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [2:0]  arb_state;

  int checks = 0;
  int passed = 0;
  int oam_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;
  logic [7:0] rd_pipe [LAT];

  always #20 clk = ~clk;

  mem_bus_arbiter #(
    .DMA_REG    (16'h4014),
    .OAM_DATA   (16'h2004),
    .MEM_RD_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sys_req      (sys_req),
    .sys_addr     (sys_addr),
    .sys_wdata    (sys_wdata),
    .sys_we       (sys_we),
    .sys_re       (sys_re),
    .sys_gnt      (sys_gnt),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_re       (cpu_re),
    .cpu_halt_ext (cpu_halt_ext),
    .cpu_halt     (cpu_halt),
    .mem_busy     (mem_busy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .dma_active   (dma_active),
    .arb_state    (arb_state)
  );

  // Memory contents: page 2 holds i^A5; other pages are offset so a wrong page is visible.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
  endfunction

  // Read data appears LAT cycles after the mem_re cycle and then holds.
  always @(posedge clk) begin
    rd_pipe[0] <= mem_re ? src_byte(mem_addr) : rd_pipe[0];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Scoreboard: every OAM write pops the next expected byte.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_addr == 16'h2004) begin
      oam_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL oam_extra: got write data %02h, none expected", mem_wdata);
      end else begin
        exp_d = exp_q.pop_front();
        if (mem_wdata !== exp_d) $display("FAIL oam_data: got %02h, expected %02h", mem_wdata, exp_d);
        else passed++;
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_dma(input logic [7:0] page);
    for (int i = 0; i < 256; i++) exp_q.push_back(src_byte({page, 8'(i)}));
  endtask

  task automatic trigger(input logic [7:0] page);
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = page;
    push_dma(page);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic wait_rd(input logic [15:0] a, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (mem_re === 1'b1 && mem_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (cpu_halt === 1'b0) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_re = 1'b1; cpu_addr = 16'h8000;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_we, mem_re} !== 2'b00) $display("FAIL reset_strobes: got we/re %b, expected 00", {mem_we, mem_re});
    else passed++;
    checks++;
    if ({arb_state, sys_gnt, dma_active} !== 5'b000_0_0)
      $display("FAIL reset_state: got state %0d gnt %b active %b, expected 0 0 0", arb_state, sys_gnt, dma_active);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic test_idle();
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 16'h8000;
    @(negedge clk);
    checks++;
    if ({mem_re, mem_we, mem_addr, cpu_halt, arb_state} !== {1'b1, 1'b0, 16'h8000, 1'b0, 3'd0})
      $display("FAIL idle_read: got re %b we %b addr %04h halt %b state %0d, expected 1 0 8000 0 0",
               mem_re, mem_we, mem_addr, cpu_halt, arb_state);
    else passed++;
    @(posedge clk); #1;
    mem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_re, cpu_halt} !== 2'b01) $display("FAIL idle_busy: got re %b halt %b, expected 0 1", mem_re, cpu_halt);
    else passed++;
    @(posedge clk); #1;
    mem_busy = 1'b0; cpu_halt_ext = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_halt !== 1'b1) $display("FAIL idle_halt_ext: got halt %b, expected 1", cpu_halt);
    else passed++;
    @(posedge clk); #1;
    cpu_halt_ext = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic test_dma_full();
    int cyc; bit ok; int base;
    base = oam_cnt;
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
    push_dma(8'h02);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h4014, 8'h02})
      $display("FAIL trig_forward: got we %b addr %04h data %02h, expected 1 4014 02", mem_we, mem_addr, mem_wdata);
    else passed++;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    wait_idle(cyc, ok);
    checks++;
    if (!ok || cyc != DMA_CYC) $display("FAIL dma_halt_len: got %0d halted cycles (done %b), expected %0d", cyc, ok, DMA_CYC);
    else passed++;
    checks++;
    if ({arb_state, dma_active} !== {3'd0, 1'b0} || oam_cnt - base != 256 || exp_q.size() != 0)
      $display("FAIL dma_end: got state %0d active %b writes %0d left %0d, expected 0 0 256 0",
               arb_state, dma_active, oam_cnt - base, exp_q.size());
    else passed++;
  endtask

  task automatic test_sys_preempt();
    int cyc; bit ok; int base;
    base = oam_cnt;
    trigger(8'h03);
    wait_rd(16'h030A, ok);
    sys_req = 1'b1;
    cyc = 0;
    for (int n = 0; n < 20 && sys_gnt !== 1'b1; n++) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ({sys_gnt, arb_state, dma_active} !== {1'b1, 3'd1, 1'b1} || oam_cnt - base != 11 || cyc != LAT + 2)
      $display("FAIL sys_grant: got gnt %b state %0d active %b writes %0d after %0d cycles, expected 1 1 1 11 after %0d",
               sys_gnt, arb_state, dma_active, oam_cnt - base, cyc, LAT + 2);
    else passed++;
    @(posedge clk); #1;
    sys_we = 1'b1; sys_addr = 16'h0300; sys_wdata = 8'h55;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0300, 8'h55})
      $display("FAIL sys_write: got we %b addr %04h data %02h, expected 1 0300 55", mem_we, mem_addr, mem_wdata);
    else passed++;
    @(posedge clk); #1;
    sys_we = 1'b0; sys_addr = 16'h0000; sys_wdata = 8'h00; sys_req = 1'b0;
    wait_rd(16'h030B, ok);
    checks++;
    if (!ok || oam_cnt - base != 11) $display("FAIL sys_resume: got found %b writes %0d, expected 1 11", ok, oam_cnt - base);
    else passed++;
    wait_idle(cyc, ok);
    checks++;
    if (!ok || sys_gnt !== 1'b0 || oam_cnt - base != 256 || exp_q.size() != 0)
      $display("FAIL sys_dma_end: got done %b gnt %b writes %0d left %0d, expected 1 0 256 0",
               ok, sys_gnt, oam_cnt - base, exp_q.size());
    else passed++;
  endtask

  task automatic test_sys_same_cycle();
    int cyc; bit ok; int base; int bad;
    base = oam_cnt;
    @(posedge clk); #1;
    sys_req = 1'b1; sys_we = 1'b1; sys_addr = 16'h1234; sys_wdata = 8'hEE;
    cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h04;
    push_dma(8'h04);
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata, sys_gnt} !== {1'b1, 16'h4014, 8'h04, 1'b0})
      $display("FAIL same_forward: got we %b addr %04h data %02h gnt %b, expected 1 4014 04 0",
               mem_we, mem_addr, mem_wdata, sys_gnt);
    else passed++;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; sys_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({sys_gnt, arb_state, dma_active} !== {1'b1, 3'd1, 1'b1})
      $display("FAIL same_sys_first: got gnt %b state %0d active %b, expected 1 1 1", sys_gnt, arb_state, dma_active);
    else passed++;
    repeat (3) @(posedge clk);
    #1 sys_req = 1'b0;
    bad = 0;
    ok = 1'b0;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (cpu_halt === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (dma_active !== 1'b1) bad++;
      cyc++;
    end
    checks++;
    if (bad != 0 || !ok) $display("FAIL same_active: got %0d cycles with dma_active low (done %b), expected 0", bad, ok);
    else passed++;
    // One SYS release cycle, then a full DMA without the alignment cycle.
    checks++;
    if (cyc != 1 + 256 * (2 + LAT) || oam_cnt - base != 256 || exp_q.size() != 0)
      $display("FAIL same_dma: got %0d cycles writes %0d left %0d, expected %0d 256 0",
               cyc, oam_cnt - base, exp_q.size(), 1 + 256 * (2 + LAT));
    else passed++;
  endtask

  task automatic test_busy();
    int cyc; bit ok; int base; int bad;
    base = oam_cnt;
    trigger(8'h05);
    wait_rd(16'h0514, ok);
    repeat (LAT + 1) @(posedge clk);
    #1 mem_busy = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || mem_re !== 1'b0 || arb_state !== 3'd5) bad++;
    end
    checks++;
    if (!ok || bad != 0 || oam_cnt - base != 20)
      $display("FAIL busy_stall: got found %b bad cycles %0d writes %0d, expected 1 0 20", ok, bad, oam_cnt - base);
    else passed++;
    @(posedge clk); #1;
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h2004, src_byte(16'h0514)})
      $display("FAIL busy_reissue: got we %b addr %04h data %02h, expected 1 2004 %02h",
               mem_we, mem_addr, mem_wdata, src_byte(16'h0514));
    else passed++;
    wait_idle(cyc, ok);
    checks++;
    if (!ok || oam_cnt - base != 256 || exp_q.size() != 0)
      $display("FAIL busy_dma_end: got done %b writes %0d left %0d, expected 1 256 0", ok, oam_cnt - base, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int base;
    base = oam_cnt;
    trigger(8'h06);
    wait_rd(16'h0664, ok);
    repeat (LAT + 1) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || {mem_we, mem_re} !== 2'b00 || oam_cnt - base != 100)
      $display("FAIL rst_cycle: got found %b we/re %b writes %0d, expected 1 00 100", ok, {mem_we, mem_re}, oam_cnt - base);
    else passed++;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({arb_state, dma_active, sys_gnt, mem_we, mem_re, cpu_halt} !== {3'd0, 5'b00000})
      $display("FAIL rst_after: got state %0d active %b gnt %b we %b re %b halt %b, expected 0 0 0 0 0 0",
               arb_state, dma_active, sys_gnt, mem_we, mem_re, cpu_halt);
    else passed++;
    base = oam_cnt;
    trigger(8'h07);
    wait_rd(16'h0700, ok);
    checks++;
    if (!ok || oam_cnt - base != 0) $display("FAIL rst_restart: got found %b writes %0d, expected 1 0", ok, oam_cnt - base);
    else passed++;
    wait_idle(cyc, ok);
    checks++;
    if (!ok || oam_cnt - base != 256 || exp_q.size() != 0)
      $display("FAIL rst_dma_end: got done %b writes %0d left %0d, expected 1 256 0", ok, oam_cnt - base, exp_q.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1; sys_req = 1'b0; sys_addr = 16'h0000; sys_wdata = 8'h00; sys_we = 1'b0; sys_re = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_re = 1'b0; cpu_halt_ext = 1'b0;
    mem_busy = 1'b0;
    test_reset();
    test_idle();
    test_dma_full();
    test_sys_preempt();
    test_sys_same_cycle();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
